// File: rtl/fxdiv_pkg.sv
// Shared types and constants for the fixed-point restoring divider.
package fxdiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CALC,
    S_ROUND,
    S_SIGN,
    S_HOLD
  } state_t;

  localparam logic RND_TRUNC = 1'b0;
  localparam logic RND_RNE   = 1'b1;

endpackage

// File: rtl/fxdiv_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract divisor if it fits.
module fxdiv_step #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W-1:0] shifted;

  // The true difference is always below 2^W, so a W-bit modular subtract is exact.
  always_comb begin
    shifted = {rem_i[W-2:0], bit_i};
    q_o     = ({rem_i, bit_i} >= {1'b0, div_i});
    rem_o   = q_o ? (shifted - div_i) : shifted;
  end

endmodule

// File: rtl/fxdiv_rv.sv
// Sequential fixed-point divider with valid/ready handshake, rounding and saturation.
module fxdiv_rv
  import fxdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FBITS = 8,
  parameter int unsigned TAGW  = 4,
  parameter int unsigned SAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  input  logic             in_round,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [TAGW-1:0]  out_tag,
  output logic             out_dbz,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned ITER = WIDTH + FBITS;
  localparam int unsigned CNTW = $clog2(ITER + 1);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [ITER:0] LIM_SPOS = {{(ITER-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [ITER:0] LIM_SNEG = LIM_SPOS + 1'b1;
  localparam logic [ITER:0] LIM_U    = {{(ITER-WIDTH+1){1'b0}}, {WIDTH{1'b1}}};

  state_t            state_q, state_d;
  logic [ITER-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]  div_q, div_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [ITER:0]     mag_q, mag_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              sgn_q, sgn_d;
  logic              rnd_q, rnd_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic              dbz_q, dbz_d;
  logic              ovf_q, ovf_d;
  logic              ovalid_q, ovalid_d;
  logic              busy_q, busy_d;

  logic [WIDTH-1:0]  a_mag, b_mag, rem_step;
  logic              step_bit, q_bit, inc;
  logic [ITER:0]     lim;
  logic              over;

  fxdiv_step #(.W(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (step_bit),
    .div_i (div_q),
    .rem_o (rem_step),
    .q_o   (q_bit)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = ovalid_q;
  assign out_q     = res_q;
  assign out_tag   = tag_q;
  assign out_dbz   = dbz_q;
  assign out_ovf   = ovf_q;
  assign busy      = busy_q;

  always_comb begin
    a_mag    = (in_signed && in_a[WIDTH-1]) ? (~in_a + 1'b1) : in_a;
    b_mag    = (in_signed && in_b[WIDTH-1]) ? (~in_b + 1'b1) : in_b;
    // In ROUND the step unit is reused with a zero bit to form the guard bit.
    step_bit = (state_q == S_CALC) ? dvd_q[ITER-1] : 1'b0;
    inc      = (rnd_q == RND_RNE) && q_bit && (dvd_q[0] || (rem_step != '0));
    lim      = !sgn_q ? LIM_U : (neg_q ? LIM_SNEG : LIM_SPOS);
    over     = (mag_q > lim);

    state_d  = state_q;
    dvd_d    = dvd_q;
    div_d    = div_q;
    rem_d    = rem_q;
    mag_d    = mag_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    sgn_d    = sgn_q;
    rnd_d    = rnd_q;
    res_d    = res_q;
    tag_d    = tag_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    ovalid_d = ovalid_q;
    busy_d   = busy_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          busy_d = 1'b1;
          tag_d  = in_tag;
          sgn_d  = in_signed;
          rnd_d  = in_round;
          neg_d  = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
          div_d  = b_mag;
          dvd_d  = ITER'(a_mag) << FBITS;
          dbz_d  = 1'b0;
          ovf_d  = 1'b0;
          if (in_b == '0) begin
            dbz_d   = 1'b1;
            res_d   = !in_signed ? '1 : (in_a[WIDTH-1] ? SMIN : SMAX);
            state_d = S_HOLD;
          end else begin
            state_d = S_INIT;
          end
        end
      end
      S_INIT: begin
        rem_d   = '0;
        cnt_d   = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        dvd_d = {dvd_q[ITER-2:0], q_bit};
        rem_d = rem_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNTW'(ITER - 1)) state_d = S_ROUND;
      end
      S_ROUND: begin
        mag_d   = {1'b0, dvd_q} + (ITER+1)'(inc);
        state_d = S_SIGN;
      end
      S_SIGN: begin
        ovf_d = over;
        if (over)
          res_d = (SAT == 0) ? '0 : (!sgn_q ? '1 : (neg_q ? SMIN : SMAX));
        else if (neg_q)
          res_d = ~mag_q[WIDTH-1:0] + 1'b1;
        else
          res_d = mag_q[WIDTH-1:0];
        ovalid_d = 1'b1;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        // The divide-by-zero path arrives here with out_valid still low.
        if (!ovalid_q) begin
          ovalid_d = 1'b1;
        end else if (out_ready) begin
          ovalid_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dvd_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      mag_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      sgn_q    <= 1'b0;
      rnd_q    <= 1'b0;
      res_q    <= '0;
      tag_q    <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      ovalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      sgn_q    <= sgn_d;
      rnd_q    <= rnd_d;
      res_q    <= res_d;
      tag_q    <= tag_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
      ovalid_q <= ovalid_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_fxdiv_rv.sv
// Directed table-driven bench for fxdiv_rv at WIDTH=16, FBITS=8, SAT=1.
module tb_fxdiv_rv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_signed, in_round;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready, out_dbz, out_ovf, busy;
  logic [15:0] out_q;
  logic [3:0]  out_tag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic        rnd;
    logic [3:0]  tag;
    logic [15:0] q;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  fxdiv_rv #(.WIDTH(16), .FBITS(8), .TAGW(4), .SAT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_round(in_round),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_tag(out_tag), .out_dbz(out_dbz), .out_ovf(out_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                              input logic sgn, input logic rnd, input logic [3:0] tag,
                              input logic [15:0] q, input logic dbz, input logic ovf);
    vec_t v;
    v.a = a; v.b = b; v.sgn = sgn; v.rnd = rnd; v.tag = tag;
    v.q = q; v.dbz = dbz; v.ovf = ovf;
    v.lat = dbz ? 1 : 27;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_a = v.a; in_b = v.b; in_signed = v.sgn; in_round = v.rnd; in_tag = v.tag;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int n;
    wait_ready();
    @(negedge clk);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk($sformatf("v%0d_ready", idx), {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk($sformatf("v%0d_busy", idx), {63'd0, busy}, 64'd1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk($sformatf("v%0d_latency", idx), 64'(n), 64'(v.lat));
    chk($sformatf("v%0d_q", idx), {48'd0, out_q}, {48'd0, v.q});
    chk($sformatf("v%0d_dbz", idx), {63'd0, out_dbz}, {63'd0, v.dbz});
    chk($sformatf("v%0d_ovf", idx), {63'd0, out_ovf}, {63'd0, v.ovf});
    chk($sformatf("v%0d_tag", idx), {60'd0, out_tag}, {60'd0, v.tag});
    @(posedge clk); #1;
    chk($sformatf("v%0d_valid_drop", idx), {63'd0, out_valid}, 64'd0);
    chk($sformatf("v%0d_ready_back", idx), {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int n;
    vec_t v;

    vecs.push_back(mk(16'h0300, 16'h0200, 1, 0, 4'h1, 16'h0180, 0, 0));
    vecs.push_back(mk(16'h0003, 16'h0200, 1, 0, 4'h2, 16'h0001, 0, 0));
    vecs.push_back(mk(16'h0003, 16'h0200, 1, 1, 4'h3, 16'h0002, 0, 0));
    vecs.push_back(mk(16'h0001, 16'h0200, 1, 1, 4'h4, 16'h0000, 0, 0));
    vecs.push_back(mk(16'h8000, 16'h0100, 1, 0, 4'h5, 16'h8000, 0, 0));
    vecs.push_back(mk(16'h8000, 16'hFF00, 1, 0, 4'h6, 16'h7FFF, 0, 1));
    vecs.push_back(mk(16'hFF00, 16'h0000, 1, 0, 4'h7, 16'h8000, 1, 0));
    vecs.push_back(mk(16'hFF00, 16'h0080, 0, 0, 4'h8, 16'hFFFF, 0, 1));
    vecs.push_back(mk(16'h0100, 16'h0000, 0, 0, 4'h9, 16'hFFFF, 1, 0));
    vecs.push_back(mk(16'h0000, 16'h0000, 1, 1, 4'hB, 16'h7FFF, 1, 0));
    vecs.push_back(mk(16'hFFFD, 16'h0200, 1, 1, 4'hC, 16'hFFFE, 0, 0));
    vecs.push_back(mk(16'hFFFD, 16'h0200, 1, 0, 4'hD, 16'hFFFF, 0, 0));
    vecs.push_back(mk(16'h0200, 16'h0300, 1, 0, 4'hE, 16'h00AA, 0, 0));
    vecs.push_back(mk(16'h0200, 16'h0300, 1, 1, 4'hF, 16'h00AB, 0, 0));
    vecs.push_back(mk(16'hFFFF, 16'h7F00, 1, 1, 4'h0, 16'h0000, 0, 0));
    vecs.push_back(mk(16'hFFFF, 16'h0100, 0, 0, 4'h1, 16'hFFFF, 0, 0));
    vecs.push_back(mk(16'h8000, 16'h0080, 0, 0, 4'h2, 16'hFFFF, 0, 1));
    vecs.push_back(mk(16'h7FFF, 16'h0080, 1, 0, 4'h3, 16'h7FFF, 0, 1));
    vecs.push_back(mk(16'h8000, 16'h0080, 1, 0, 4'h4, 16'h8000, 0, 1));
    vecs.push_back(mk(16'h0400, 16'hFE00, 1, 0, 4'h5, 16'hFE00, 0, 0));

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_signed = 1'b0; in_round = 1'b0; in_tag = '0;
    #12;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_q", {48'd0, out_q}, 64'd0);
    chk("rst_tag", {60'd0, out_tag}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i], i);

    // Backpressure: result must stay frozen while busy inputs toggle.
    v = mk(16'h0300, 16'h0200, 1, 0, 4'hA, 16'h0180, 0, 0);
    wait_ready();
    @(negedge clk);
    drive(v); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_a = 16'h1234; in_b = 16'h0000; in_tag = 4'h5;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("hold_latency", 64'(n), 64'd27);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_valid", c), {63'd0, out_valid}, 64'd1);
      chk($sformatf("hold%0d_q", c), {48'd0, out_q}, 64'h0180);
      chk($sformatf("hold%0d_tag", c), {60'd0, out_tag}, 64'hA);
      chk($sformatf("hold%0d_ready", c), {63'd0, in_ready}, 64'd0);
      chk($sformatf("hold%0d_busy", c), {63'd0, busy}, 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_valid", {63'd0, out_valid}, 64'd0);
    chk("hold_release_busy", {63'd0, busy}, 64'd0);
    chk("hold_release_ready", {63'd0, in_ready}, 64'd1);

    // Reset mid-calculation.
    v = vecs[0];
    @(negedge clk);
    drive(v); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op(vecs[2], 100);

    // Reset while holding a divide-by-zero result.
    v = vecs[6];
    @(negedge clk);
    drive(v); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("holdrst_pre_dbz", {63'd0, out_dbz}, 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("holdrst_valid", {63'd0, out_valid}, 64'd0);
    chk("holdrst_q", {48'd0, out_q}, 64'd0);
    chk("holdrst_tag", {60'd0, out_tag}, 64'd0);
    chk("holdrst_dbz", {63'd0, out_dbz}, 64'd0);
    chk("holdrst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(vecs[13], 101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
